// File: rtl/muldiv_hilo_unit_pkg.sv
// muldiv_hilo_unit shared definitions:
// op encodings, FSM states, cycle defaults.
package muldiv_hilo_unit_pkg;

  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 33;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic logic [31:0] abs32(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// EX-stage bundle between the pipeline
// and the mul/div HI/LO unit.
interface muldiv_hilo_unit_if;
  logic [2:0]  EX_MulDivOp;
  logic        EX_ReadHiLo;
  logic [31:0] EX_Databus1;
  logic [31:0] EX_Databus2;
  logic        Stall;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output EX_MulDivOp, EX_ReadHiLo,
    output EX_Databus1, EX_Databus2,
    input  Stall, Busy, HI, LO
  );

  modport slave (
    input  EX_MulDivOp, EX_ReadHiLo,
    input  EX_Databus1, EX_Databus2,
    output Stall, Busy, HI, LO
  );
endinterface

// File: rtl/muldiv_divider.sv
// Iterative restoring divider: one quotient
// bit per cycle, sign-fix on the outputs.
module muldiv_divider
  import muldiv_hilo_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sgn_i,
  output logic [31:0] q_o,
  output logic [31:0] r_o,
  output logic        done_o
);

  logic [31:0] rem_q, quo_q, dvs_q;
  logic [31:0] rem_d, quo_d;
  logic        negq_q, negr_q;
  logic [5:0]  iter_q;
  logic [32:0] part, diff;

  // one restoring step on the current partial remainder
  always_comb begin
    part  = {rem_q, quo_q[31]};
    diff  = part - {1'b0, dvs_q};
    rem_d = part[31:0];
    quo_d = {quo_q[30:0], 1'b0};
    if (!diff[32]) begin
      rem_d = diff[31:0];
      quo_d = {quo_q[30:0], 1'b1};
    end
  end

  // load magnitudes on start, then iterate 32 times
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      iter_q <= '0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= abs32(a_i, sgn_i);
      dvs_q  <= abs32(b_i, sgn_i);
      negq_q <= sgn_i & (a_i[31] ^ b_i[31]);
      negr_q <= sgn_i & a_i[31];
      iter_q <= 6'd32;
    end else if (iter_q != '0) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      iter_q <= iter_q - 6'd1;
    end
  end

  assign q_o    = negq_q ? -quo_q : quo_q;
  assign r_o    = negr_q ? -rem_q : rem_q;
  assign done_o = (iter_q == '0);

endmodule

// File: rtl/muldiv_hilo_unit.sv
// EX-stage MULT/DIV engine with HI/LO and
// hazard stall for HI/LO users in flight.
module muldiv_hilo_unit
  import muldiv_hilo_unit_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  muldiv_hilo_unit_if.slave bus
);

  localparam int MAXC =
    (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  md_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic        sgn_q, is_div_q;
  md_op_e      op;
  logic        idle, is_md, is_dv, div_start;
  logic [31:0] dq, dr;
  logic        div_done;
  logic [63:0] a64, b64, prod, res;

  assign op    = md_op_e'(bus.EX_MulDivOp);
  assign idle  = (state_q == ST_IDLE);
  assign is_md = op inside {MD_MULT, MD_MULTU,
                            MD_DIV, MD_DIVU};
  assign is_dv = op inside {MD_DIV, MD_DIVU};
  assign div_start = idle && is_dv;

  muldiv_divider u_div (
    .clk    (clk),
    .rst_n  (reset),
    .start_i(div_start),
    .a_i    (bus.EX_Databus1),
    .b_i    (bus.EX_Databus2),
    .sgn_i  (op == MD_DIV),
    .q_o    (dq),
    .r_o    (dr),
    .done_o (div_done)
  );

  assign a64  = {{32{sgn_q & a_q[31]}}, a_q};
  assign b64  = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod = a64 * b64;
  assign res  = is_div_q ? {dr, dq} : prod;

  // issue, count down, retire into HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          unique case (1'b1)
            is_md: begin
              a_q      <= bus.EX_Databus1;
              b_q      <= bus.EX_Databus2;
              sgn_q    <= (op == MD_MULT) ||
                          (op == MD_DIV);
              is_div_q <= is_dv;
              cnt_q    <= is_dv ? CW'(DIV_CYCLES)
                                : CW'(MUL_CYCLES);
              state_q  <= ST_BUSY;
            end
            (op == MD_MTHI): hi_q <= bus.EX_Databus1;
            (op == MD_MTLO): lo_q <= bus.EX_Databus1;
            default: ;
          endcase
        end
        ST_BUSY: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1) &&
              (!is_div_q || div_done)) begin
            {hi_q, lo_q} <= res;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.Stall = !idle &&
    (bus.EX_ReadHiLo || (op inside {MD_MULT, MD_MULTU,
      MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO}));
  assign bus.Busy = !idle;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule
